img_port_arbiter: RTL and testbench
===================================

// Module: img_port_arbiter
// PURPOSE
//  Shares the single 64x64 image port (row/col select, out_we, out_pix, in_pix) between the
//  grayscale, compression and encoding engines. Registered one-hot grant, round-robin rotation,
//  burst ownership with a hold limit, and read-data return to the owner.
//  Sits between the processing engines and the image memory model.
// PARAMETERS
//  NREQ     3   number of requesters (0=gray, 1=compress, 2=encode)
//  ADDR_W   6   row/col width (64x64 image)
//  PIX_W    24  pixel width (R 23:16, G 15:8, B 7:0)
//  MAX_HOLD 16  granted cycles before an unlocked owner is preempted when another requester waits
// PORTS
//  clk      in  1            single clock, all logic on posedge
//  rst_n    in  1            reset, synchronous, active-low
//  req      in  NREQ         per-requester access request, held for the whole burst
//  lock     in  NREQ         owner forbids preemption while high
//  req_row  in  NREQ*ADDR_W  per-requester row, slice i = [i*ADDR_W +: ADDR_W]
//  req_col  in  NREQ*ADDR_W  per-requester col
//  req_we   in  NREQ         per-requester write enable
//  req_pix  in  NREQ*PIX_W   per-requester write data
//  in_pix   in  PIX_W        image read data for the current row/col
//  gnt      out NREQ         one-hot grant, registered
//  row      out ADDR_W       muxed owner row
//  col      out ADDR_W       muxed owner col
//  out_we   out 1            req_we[owner] & req[owner] & gnt[owner]
//  out_pix  out PIX_W        muxed owner write data
//  rd_pix   out PIX_W        in_pix registered one cycle
//  rd_valid out NREQ         one-hot; bit i high the cycle after a granted read by i
//  busy     out 1            |gnt
// BEHAVIOUR
//  Reset (rst_n low at posedge): gnt=0, rd_valid=0, rd_pix=0, hold_cnt=0, rr_ptr=0, state=IDLE.
//   Muxed outputs (row, col, out_pix, out_we) are 0 when gnt==0. Mid-burst reset drops the grant
//   at that edge; no write is issued in the reset cycle.
//  FSM: IDLE -> OWN when any req at posedge: winner = first req at or after rr_ptr (wrapping);
//   gnt[winner]=1 from the next cycle (1-cycle grant latency); rr_ptr <= winner+1 mod NREQ.
//  OWN: hold_cnt increments each cycle, saturating at MAX_HOLD.
//   Owner drops req -> at that edge re-arbitrate among the others; winner granted the following
//   cycle with no idle cycle; no other req -> IDLE.
//   Preemption: hold_cnt==MAX_HOLD & ~lock[owner] & another req -> switch to next RR winner at
//   that edge; hold_cnt <= 0. The preempted requester keeps req high and waits its turn.
//   lock high: no preemption; hold_cnt saturates.
//  Invariants: gnt is one-hot or zero; out_we never high without gnt; req_we of non-owners ignored.
//  Read return: rd_pix <= in_pix every cycle; rd_valid[i] <= gnt[i] & req[i] & ~req_we[i].
//   Owner samples rd_pix when rd_valid[i]; valid even if the grant moved in between.
//  Simultaneous requests: rr_ptr decides; after reset requester 0 (gray) wins ties.
//  Requester raising req in the same cycle another drops it: handled in the same arbitration.
// CONFIGURATION
//  ARB_STATS_EN defined: adds output gnt_cnt [NREQ*16-1:0], per-requester 16-bit count of granted
//   access cycles (req & gnt), saturating at 16'hFFFF, cleared by rst_n.
//  ARB_STATS_EN undefined: no port, no counters; all other behaviour identical.
// STRUCTURE
//  img_pkg: ADDR_W, PIX_W, NREQ defaults; requester IDs REQ_GRAY=0, REQ_COMPR=1, REQ_ENC=2;
//   arbiter state enum {IDLE, OWN}.
//  Sub-module rr_pick: combinational round-robin picker (req vector, rr_ptr) -> one-hot winner + valid.
// TESTING
//  1 rst_n low, then req=3'b001, req_row/col=5/7, read -> gnt=001 one cycle later; row=5, col=7;
//    rd_valid=001 next cycle; rd_pix = pixel (5,7).
//  2 req=3'b111 from reset, each drops req after 2 cycles -> grant order 0,1,2, no idle gap.
//  3 req0 write burst 40 cycles, lock=0, req2 arrives at cycle 3 -> req0 preempted after
//    16 granted cycles; gnt=100; after req2 drops, gnt returns to 001.
//  4 Same as 3 with lock[0]=1 -> gnt stays 001 for all 40 cycles; req2 granted the cycle after
//    req0 drops.
//  5 rst_n low mid-write burst (out_we=1) -> next cycle gnt=0, out_we=0, rr_ptr=0; no stray write.
//  6 ARB_STATS_EN, req1 granted 70000 cycles -> gnt_cnt[31:16] saturates at 16'hFFFF.

Source files
------------

// File: rtl/img_pkg.sv
// Shared constants and types for the image-port arbiter.
package img_pkg;
  localparam int IMG_NREQ     = 3;
  localparam int IMG_ADDR_W   = 6;
  localparam int IMG_PIX_W    = 24;
  localparam int IMG_MAX_HOLD = 16;

  localparam int REQ_GRAY  = 0;
  localparam int REQ_COMPR = 1;
  localparam int REQ_ENC   = 2;

  typedef enum logic {IDLE, OWN} arb_state_e;
endpackage

// File: rtl/img_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);
  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!vld_o && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
        vld_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/img_port_arbiter.sv
// Round-robin arbiter sharing the 64x64 image port among the processing engines.
// Define ARB_STATS_EN to add per-requester saturating grant counters on gnt_cnt_o.
module img_port_arbiter import img_pkg::*; #(
  parameter int NREQ     = IMG_NREQ,
  parameter int ADDR_W   = IMG_ADDR_W,
  parameter int PIX_W    = IMG_PIX_W,
  parameter int MAX_HOLD = IMG_MAX_HOLD
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ-1:0]        lock_i,
  input  logic [NREQ*ADDR_W-1:0] req_row_i,
  input  logic [NREQ*ADDR_W-1:0] req_col_i,
  input  logic [NREQ-1:0]        req_we_i,
  input  logic [NREQ*PIX_W-1:0]  req_pix_i,
  input  logic [PIX_W-1:0]       in_pix_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [ADDR_W-1:0]      row_o,
  output logic [ADDR_W-1:0]      col_o,
  output logic                   out_we_o,
  output logic [PIX_W-1:0]       out_pix_o,
  output logic [PIX_W-1:0]       rd_pix_o,
  output logic [NREQ-1:0]        rd_valid_o,
  output logic                   busy_o
`ifdef ARB_STATS_EN
  , output logic [NREQ*16-1:0]   gnt_cnt_o
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [NREQ-1:0]  rd_valid_q;
  logic [PIX_W-1:0] rd_pix_q;

  logic [NREQ-1:0]  cand, win;
  logic [IW-1:0]    win_idx, win_nxt;
  logic             win_vld, owner_req, owner_lock, preempt;

  // The current owner never competes against itself; in IDLE gnt_q is zero.
  assign cand       = req_i & ~gnt_q;
  assign owner_req  = |(req_i & gnt_q);
  assign owner_lock = |(lock_i & gnt_q);
  assign preempt    = (hold_q == HW'(MAX_HOLD)) && !owner_lock && win_vld;
  assign win_nxt    = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req_i (cand),
    .ptr_i (rr_ptr_q),
    .gnt_o (win),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  // hold_q counts owned cycles including the current one, so an owner gets MAX_HOLD cycles.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_d    = win;
          rr_ptr_d = win_nxt;
          hold_d   = HW'(1);
          state_d  = OWN;
        end
      end
      OWN: begin
        if (!owner_req || preempt) begin
          if (win_vld) begin
            gnt_d    = win;
            rr_ptr_d = win_nxt;
            hold_d   = HW'(1);
          end else begin
            gnt_d   = '0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      hold_q     <= '0;
      rd_valid_q <= '0;
      rd_pix_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_q     <= hold_d;
      rd_valid_q <= gnt_q & req_i & ~req_we_i;
      rd_pix_q   <= in_pix_i;
    end
  end

  always_comb begin
    row_o     = '0;
    col_o     = '0;
    out_pix_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      row_o     = row_o     | (req_row_i[i*ADDR_W +: ADDR_W] & {ADDR_W{gnt_q[i]}});
      col_o     = col_o     | (req_col_i[i*ADDR_W +: ADDR_W] & {ADDR_W{gnt_q[i]}});
      out_pix_o = out_pix_o | (req_pix_i[i*PIX_W +: PIX_W]   & {PIX_W{gnt_q[i]}});
    end
  end

  // Suppress the write while reset is asserted so a mid-burst reset never commits a pixel.
  assign out_we_o   = rst_n_i & |(gnt_q & req_i & req_we_i);
  assign gnt_o      = gnt_q;
  assign busy_o     = |gnt_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_pix_o   = rd_pix_q;

`ifdef ARB_STATS_EN
  logic [NREQ-1:0][15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (gnt_q[i] && req_i[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  assign gnt_cnt_o = cnt_q;
`endif
endmodule

// File: tb/tb_img_port_arbiter.sv
// Scoreboard bench for img_port_arbiter: each driven cycle pushes its expected outputs.
module tb_img_port_arbiter;
  import img_pkg::*;
  localparam int N  = IMG_NREQ;
  localparam int AW = IMG_ADDR_W;
  localparam int PW = IMG_PIX_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0, lock = '0, req_we = '0;
  logic [N*AW-1:0] req_row = '0, req_col = '0;
  logic [N*PW-1:0] req_pix = '0;
  logic [PW-1:0]   in_pix;
  logic [N-1:0]    gnt, rd_valid;
  logic [AW-1:0]   row, col;
  logic            out_we, busy;
  logic [PW-1:0]   out_pix, rd_pix;
`ifdef ARB_STATS_EN
  logic [N*16-1:0] gnt_cnt;
`endif

  img_port_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .lock_i(lock),
    .req_row_i(req_row), .req_col_i(req_col), .req_we_i(req_we), .req_pix_i(req_pix),
    .in_pix_i(in_pix), .gnt_o(gnt), .row_o(row), .col_o(col), .out_we_o(out_we),
    .out_pix_o(out_pix), .rd_pix_o(rd_pix), .rd_valid_o(rd_valid), .busy_o(busy)
`ifdef ARB_STATS_EN
    , .gnt_cnt_o(gnt_cnt)
`endif
  );

  function automatic logic [PW-1:0] pixf(input logic [AW-1:0] r, input logic [AW-1:0] c);
    return {r, c, r ^ c, 6'h15};
  endfunction

  function automatic logic [AW-1:0] row_of(input int i); return AW'(5 + 8*i); endfunction
  function automatic logic [AW-1:0] col_of(input int i); return AW'(7 + 8*i); endfunction
  function automatic logic [PW-1:0] wpix_of(input int i); return PW'(24'hA0_0001 + 24'h01_0101*i); endfunction

  // image memory model
  assign in_pix = pixf(row, col);

  typedef struct {
    logic [N-1:0]  gnt, rdv;
    logic          we;
    logic [AW-1:0] row, col;
    logic [PW-1:0] opix, rdpix;
    logic          chk_rd;
  } exp_t;

  exp_t sb[$];
  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got %0h exp %0h", tag, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("gnt",      32'(gnt),      32'(e.gnt));
      chk("busy",     32'(busy),     32'(|e.gnt));
      chk("rd_valid", 32'(rd_valid), 32'(e.rdv));
      chk("out_we",   32'(out_we),   32'(e.we));
      chk("row",      32'(row),      32'(e.row));
      chk("col",      32'(col),      32'(e.col));
      chk("out_pix",  32'(out_pix),  32'(e.opix));
      if (e.chk_rd) chk("rd_pix", 32'(rd_pix), 32'(e.rdpix));
    end
  end

  // previous-cycle inputs/expectations, used for the one-cycle read return
  logic         p_rst = 1'b0;
  logic [N-1:0] p_gnt = '0, p_req = '0, p_we = '0;

  task automatic cyc(input logic rst, input logic [N-1:0] r, input logic [N-1:0] l,
                     input logic [N-1:0] w, input logic [N-1:0] eg);
    exp_t e;
    @(posedge clk); #1;
    rst_n = rst; req = r; lock = l; req_we = w;
    e.gnt = eg;
    e.we  = rst & |(eg & r & w);
    e.rdv = p_rst ? (p_gnt & p_req & ~p_we) : '0;
    e.row = '0; e.col = '0; e.opix = '0;
    for (int i = 0; i < N; i++)
      if (eg[i]) begin e.row = row_of(i); e.col = col_of(i); e.opix = wpix_of(i); end
    e.chk_rd = !p_rst || (p_gnt != '0);
    e.rdpix  = '0;
    if (p_rst)
      for (int i = 0; i < N; i++)
        if (p_gnt[i]) e.rdpix = pixf(row_of(i), col_of(i));
    sb.push_back(e);
    p_rst = rst; p_gnt = eg; p_req = r; p_we = w;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      req_row[i*AW +: AW] = row_of(i);
      req_col[i*AW +: AW] = col_of(i);
      req_pix[i*PW +: PW] = wpix_of(i);
    end

    // single gray read at (5,7)
    cyc(0, 3'b000, 3'b000, 3'b000, 3'b000);
    cyc(0, 3'b000, 3'b000, 3'b000, 3'b000);
    cyc(1, 3'b001, 3'b000, 3'b000, 3'b000);
    cyc(1, 3'b001, 3'b000, 3'b000, 3'b001);
    cyc(1, 3'b000, 3'b000, 3'b000, 3'b001);
    cyc(1, 3'b000, 3'b000, 3'b000, 3'b000);

    // all three request together; order 0,1,2 with no idle gap
    cyc(0, 3'b000, 3'b000, 3'b000, 3'b000);
    cyc(1, 3'b111, 3'b000, 3'b000, 3'b000);
    cyc(1, 3'b111, 3'b000, 3'b000, 3'b001);
    cyc(1, 3'b111, 3'b000, 3'b000, 3'b001);
    cyc(1, 3'b110, 3'b000, 3'b000, 3'b001);
    cyc(1, 3'b110, 3'b000, 3'b000, 3'b010);
    cyc(1, 3'b110, 3'b000, 3'b000, 3'b010);
    cyc(1, 3'b100, 3'b000, 3'b000, 3'b010);
    cyc(1, 3'b100, 3'b000, 3'b000, 3'b100);
    cyc(1, 3'b100, 3'b000, 3'b000, 3'b100);
    cyc(1, 3'b000, 3'b000, 3'b000, 3'b100);
    cyc(1, 3'b000, 3'b000, 3'b000, 3'b000);

    // unlocked gray write burst, encoder reads from cycle 3: preempted after 16 owned cycles
    cyc(0, 3'b000, 3'b000, 3'b000, 3'b000);
    cyc(1, 3'b001, 3'b000, 3'b001, 3'b000);
    for (int k = 1; k <= 41; k++)
      cyc(1, (k >= 40) ? 3'b000 : ((k >= 3 && k <= 20) ? 3'b101 : 3'b001), 3'b000, 3'b001,
          (k <= 16) ? 3'b001 : (k <= 21) ? 3'b100 : (k <= 40) ? 3'b001 : 3'b000);

    // same burst locked: encoder waits until gray releases
    cyc(0, 3'b000, 3'b000, 3'b000, 3'b000);
    cyc(1, 3'b001, 3'b001, 3'b001, 3'b000);
    for (int k = 1; k <= 44; k++)
      cyc(1, (k < 3) ? 3'b001 : (k <= 39) ? 3'b101 : (k <= 42) ? 3'b100 : 3'b000, 3'b001, 3'b001,
          (k <= 40) ? 3'b001 : (k <= 43) ? 3'b100 : 3'b000);

    // reset in the middle of a write burst; afterwards requester 0 wins the tie again
    cyc(0, 3'b000, 3'b000, 3'b000, 3'b000);
    cyc(1, 3'b001, 3'b000, 3'b001, 3'b000);
    for (int k = 1; k <= 4; k++) cyc(1, 3'b001, 3'b000, 3'b001, 3'b001);
    cyc(0, 3'b001, 3'b000, 3'b001, 3'b001);
    cyc(0, 3'b001, 3'b000, 3'b001, 3'b000);
    cyc(1, 3'b011, 3'b000, 3'b000, 3'b000);
    cyc(1, 3'b011, 3'b000, 3'b000, 3'b001);
    cyc(1, 3'b010, 3'b000, 3'b000, 3'b001);
    cyc(1, 3'b000, 3'b000, 3'b000, 3'b010);
    cyc(1, 3'b000, 3'b000, 3'b000, 3'b000);

`ifdef ARB_STATS_EN
    // compress engine granted long enough to saturate its counter
    @(posedge clk); #1; rst_n = 1'b0; req = '0;
    @(posedge clk); #1; rst_n = 1'b1; req = 3'b010;
    for (int k = 0; k < 70000; k++) @(posedge clk);
    #1;
    chk("gnt_cnt1_sat", 32'(gnt_cnt[REQ_COMPR*16 +: 16]), 32'hFFFF);
    chk("gnt_cnt0",     32'(gnt_cnt[REQ_GRAY*16 +: 16]),  32'h0);
    chk("gnt_cnt2",     32'(gnt_cnt[REQ_ENC*16 +: 16]),   32'h0);
    req = '0;
`endif

    @(negedge clk); #1;
    if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
